mem_arbiter: RTL
================

# mem_arbiter

Sequences a single shared single-port memory between the instruction-fetch stage (F) and the data-memory stage (M) of the 5-stage pipeline. It grants one access at a time, with data over fetch. It latches returned read data and produces `ArbStall`, which freezes the whole pipeline while either stage still waits for its access. `ArbStall` is OR-ed into the hazard unit's stall/flush network alongside the load-use and branch stalls.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack`. Used only with the timeout feature.
- `TO_W`, 8: width of the timeout counter. Must satisfy `2**TO_W > TIMEOUT`.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: F stage needs the instruction at `if_addr`.
- `if_addr` in 32: fetch address (word aligned).
- `flush_if` in 1: branch/jump redirect. Discards the current fetch.
- `if_rdata` out 32: fetched instruction. Held until the next fetch completes.
- `dm_req` in 1: M stage access (lw/sw).
- `dm_we` in 1: 1 = write.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: write data.
- `dm_be` in 4: write byte enables.
- `dm_rdata` out 32: load data. Held until the next data read completes.
- `ArbStall` out 1: freeze F/D/E/M/W.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_rdata` in 32: memory read data. Valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion strobe.
- `bus_err` out 1: one-cycle pulse on timeout. Tied 0 without the macro.

## Operation
- FSM states: IDLE, FETCH, DATA, DRAIN.
- Sticky flags `if_ok` and `dm_ok` mark that this pipeline step's access is finished.
- `ArbStall = (if_req & ~if_ok) | (dm_req & ~dm_ok)`. This is combinational from the inputs and flags.
- Both flags clear on any cycle with `ArbStall=0`, which is the edge where the pipeline advances.
- IDLE transitions:
  - If `dm_req & ~dm_ok`, go to DATA. Register `mem_*` from the `dm_*` inputs.
  - Else if `if_req & ~if_ok & ~flush_if`, go to FETCH. Register `mem_addr=if_addr`, `mem_we=0`, `mem_be=4'hF`.
  - Data has strict priority because M is the older instruction.
- DATA transitions:
  - On `mem_ack`: set `dm_ok`. If `~mem_we`, load `dm_rdata <= mem_rdata`. Go to IDLE.
- FETCH transitions:
  - On `mem_ack` with no flush: set `if_ok`, load `if_rdata`, go to IDLE.
  - On `flush_if` without ack: go to DRAIN.
  - On `flush_if` in the same cycle as ack: discard the data, go to IDLE, leave `if_ok` clear.
- DRAIN transitions:
  - Keep `mem_req` high until `mem_ack`. Discard the data. Go to IDLE.
- `flush_if` while `if_ok=1` clears `if_ok`, so the redirected address is fetched.
- `mem_*` outputs are registered and stay stable from grant until ack.
- `mem_req` drops in the cycle after ack.
- No new grant is issued in the ack cycle.
- Requesters hold their `*_req`, address and data stable while `ArbStall=1`.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; `mem_be` = 0; flags = 0; `bus_err` = 0.
- Reset mid-access: `mem_req` drops immediately. The memory must tolerate an abandoned request.
- Latency, request to flag set:
  - Request seen in IDLE at cycle t.
  - `mem_req` high at t+1.
  - Ack at t+k.
  - Flag set and rdata valid at t+k+1.
  - With k=1 this is 2 cycles.
- Both pending: data is served first, then fetch starts 1 cycle after the data flag sets. `ArbStall` stays high until both flags are set.
- Cycles with neither request: `ArbStall=0`, the FSM stays in IDLE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs in FETCH, DATA and DRAIN. It clears on entering each state.
  - When the count reaches `TIMEOUT` with no ack, the access is terminated: FSM to IDLE, `mem_req` drops.
  - The owning flag is set (none for DRAIN), its rdata is loaded with 32'h0, and `bus_err` pulses for 1 cycle.
- Undefined:
  - The FSM waits for ack indefinitely.
  - `bus_err` is constant 0. No counter logic is present.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/FETCH/DATA/DRAIN),
  - localparams for address/data width 32 and byte-enable width 4,
  - the `4'hF` fetch byte-enable constant.
- One sub-module, `mem_arb_timeout`: a `TO_W`-bit watchdog with inputs clear/enable and output expired. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Lone fetch, ack after 1 cycle, `mem_rdata=32'h8C010004`:
  - `mem_req` high for 1 cycle.
  - `if_rdata=32'h8C010004`.
  - `ArbStall` high for 2 cycles, then low.
- `if_req` and `dm_req` (lw, addr 0x100) in the same cycle:
  - Data granted first (`mem_addr=0x100`), then fetch.
  - `ArbStall` low only after both complete.
  - `dm_rdata` and `if_rdata` each correct.
- sw, `dm_be=4'b0011`, `wdata=32'hDEADBEEF`:
  - `mem_we=1`, `mem_be=0011`, stable until ack, which arrives after 4 cycles.
  - `dm_rdata` unchanged.
- `flush_if` 1 cycle into a fetch whose ack comes 3 cycles later:
  - FSM goes to DRAIN and the data is discarded.
  - Then the new `if_addr` is fetched.
  - `if_rdata` holds only the new instruction.
- `rst_n` low while in DATA:
  - All outputs return to reset values asynchronously.
  - After release, the FSM is in IDLE and a new request is served normally.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT=4`, no ack on a load:
  - Access terminated after 4 cycles.
  - `bus_err` pulses once.
  - `dm_rdata=0`.
  - `ArbStall` releases.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the F/M shared-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] FETCH_BE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Memory command held on the mem_* pins from grant until ack.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Watchdog for mem_arbiter: counts cycles while enabled and flags when TIMEOUT is reached.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count;
  logic [TO_W-1:0] count_inc;

  assign count_inc = count + TO_W'(1);

  // Saturates once expired; the owner clears it on the next state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      count   <= count_inc;
      expired <= (count_inc == TO_W'(TIMEOUT));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter for the F and M pipeline stages (data over fetch).
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush_if,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [BE_W-1:0]   dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ArbStall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  if (64'(TIMEOUT) >= (64'd1 << TO_W)) begin : g_to_w_check
    $error("mem_arbiter: TO_W too narrow for TIMEOUT");
  end

  state_t            state, state_d;
  logic              if_ok, if_ok_d;
  logic              dm_ok, dm_ok_d;
  logic              mem_req_d;
  mem_cmd_t          cmd, cmd_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;
  logic              bus_err_d;
  logic              expired;

  assign ArbStall  = (if_req & ~if_ok) | (dm_req & ~dm_ok);
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_be    = cmd.be;

`ifdef MEM_ARB_TIMEOUT_EN
  logic to_clear;
  logic to_enable;

  assign to_clear  = (state_d != state);
  assign to_enable = (state != IDLE);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      if_ok    <= 1'b0;
      dm_ok    <= 1'b0;
      mem_req  <= 1'b0;
      cmd      <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_d;
      if_ok    <= if_ok_d;
      dm_ok    <= dm_ok_d;
      mem_req  <= mem_req_d;
      cmd      <= cmd_d;
      if_rdata <= if_rdata_d;
      dm_rdata <= dm_rdata_d;
      bus_err  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state;
    if_ok_d    = if_ok;
    dm_ok_d    = dm_ok;
    mem_req_d  = mem_req;
    cmd_d      = cmd;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
    bus_err_d  = 1'b0;

    // Flags live for one pipeline step; a redirect invalidates a finished fetch.
    if (!ArbStall) begin
      if_ok_d = 1'b0;
      dm_ok_d = 1'b0;
    end
    if (flush_if) begin
      if_ok_d = 1'b0;
    end

    case (state)
      IDLE: begin
        if (dm_req && !dm_ok) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          cmd_d.we    = dm_we;
          cmd_d.addr  = dm_addr;
          cmd_d.wdata = dm_wdata;
          cmd_d.be    = dm_be;
        end else if (if_req && !if_ok && !flush_if) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          cmd_d.we   = 1'b0;
          cmd_d.addr = if_addr;
          cmd_d.be   = FETCH_BE;
        end
      end

      DATA: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_ok_d   = 1'b1;
          if (!cmd.we) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (expired) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_ok_d    = 1'b1;
          dm_rdata_d = '0;
          bus_err_d  = 1'b1;
        end
      end

      FETCH: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!flush_if) begin
            if_ok_d    = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (flush_if) begin
          state_d = DRAIN;
        end else if (expired) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ok_d    = 1'b1;
          if_rdata_d = '0;
          bus_err_d  = 1'b1;
        end
      end

      DRAIN: begin
        // The abandoned fetch must still complete on the bus; its data is dropped.
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (expired) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule
